// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one single-port, variable-latency memory.
// Data has priority; a saturating starvation counter forces a fetch grant after STARVE_LIMIT data wins.
package mem_arbiter_pkg;
  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd4,
    MEM_HU = 3'd5
  } mem_op_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  mem_op_t       d_op,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output mem_op_t       m_op,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t        state, state_nxt;
  logic          owner;
  logic [3:0]    starve_cnt;
  logic [AW-1:0] addr_q;
  logic          we_q;
  mem_op_t       op_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          any_req;
  logic          grant_data;

  // Data wins a contested slot unless fetch has already waited out the limit.
  always_comb begin
    any_req    = if_req | d_req;
    grant_data = d_req & (~if_req | (starve_cnt != LIMIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)  state_nxt = ISSUE;
      ISSUE:   if (m_gnt)    state_nxt = WAIT;
      WAIT:    if (m_rvalid) state_nxt = RESP;
      RESP:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= 1'b0;
      starve_cnt <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      op_q       <= MEM_B;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner <= grant_data;
        if (grant_data) begin
          addr_q  <= d_addr;
          we_q    <= d_we;
          op_q    <= d_op;
          wdata_q <= d_wdata;
          if (!if_req)                 starve_cnt <= '0;
          else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
        end else begin
          addr_q     <= if_addr;
          we_q       <= 1'b0;
          op_q       <= MEM_W;
          wdata_q    <= '0;
          starve_cnt <= '0;
        end
      end
      // Each port keeps its own response register so the idle port's rdata holds.
      if (state == WAIT && m_rvalid) begin
        if (owner) d_rdata_q  <= m_rdata;
        else       if_rdata_q <= m_rdata;
      end
    end
  end

  always_comb begin
    m_req    = (state == ISSUE);
    m_we     = we_q;
    m_op     = op_q;
    m_addr   = addr_q;
    m_wdata  = wdata_q;
    if_ack   = (state == RESP) & ~owner;
    d_ack    = (state == RESP) & owner;
    if_rdata = if_rdata_q;
    d_rdata  = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model predicts grant order, latency and data per cycle.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 4;

  typedef struct {
    logic          we;
    mem_op_t       op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dreq_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_ack, d_req, d_we, d_ack;
  logic [AW-1:0] if_addr, d_addr, m_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, m_wdata, m_rdata;
  mem_op_t       d_op, m_op;
  logic          m_req, m_we, m_gnt, m_rvalid;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_op(m_op), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  int            cyc;
  bit            busy;
  int            t_arb, g, r;
  bit            own;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata, x_rd;
  logic          x_we;
  mem_op_t       x_op;
  int            next_arb;
  int            starve;
  logic [DW-1:0] exp_if_rd, exp_d_rd;
  logic [DW-1:0] mem [logic [AW-1:0]];

  // requesters and knobs
  bit            f_pend, d_pend;
  logic [AW-1:0] f_cur;
  dreq_t         d_cur;
  logic [AW-1:0] f_q[$];
  dreq_t         d_q[$];
  int            req_prob = 100;
  int            plan_g = -1, plan_r = -1;
  int            extra_gnt = -1, extra_rv = -1;

  // observations
  int obs_order[$];
  int n_if_ack, n_d_ack, last_if_ack_cyc, f_rise_cyc;

  mem_op_t ops [5] = '{MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    if (mem.exists(a)) return mem[a];
    return {lo, 16'hC0DE} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk_reset_outputs(input string w);
    chk({w, "_m_req"},    64'(m_req),    64'(0));
    chk({w, "_m_we"},     64'(m_we),     64'(0));
    chk({w, "_m_op"},     64'(m_op),     64'(0));
    chk({w, "_m_addr"},   64'(m_addr),   64'(0));
    chk({w, "_m_wdata"},  64'(m_wdata),  64'(0));
    chk({w, "_if_ack"},   64'(if_ack),   64'(0));
    chk({w, "_d_ack"},    64'(d_ack),    64'(0));
    chk({w, "_if_rdata"}, 64'(if_rdata), 64'(0));
    chk({w, "_d_rdata"},  64'(d_rdata),  64'(0));
  endtask

  // One clock: check this cycle's outputs, then drive the inputs the DUT samples at its end.
  task automatic step();
    bit issuing, acking;
    issuing = busy && cyc >= t_arb + 1 && cyc <= t_arb + 1 + g;
    acking  = busy && cyc == t_arb + 3 + g + r;
    chk("m_req", 64'(m_req), 64'(issuing));
    if (issuing) begin
      chk("m_addr",  64'(m_addr),  64'(x_addr));
      chk("m_we",    64'(m_we),    64'(x_we));
      chk("m_op",    64'(m_op),    64'(x_op));
      chk("m_wdata", 64'(m_wdata), 64'(x_wdata));
    end
    if (acking) begin
      if (own) exp_d_rd = x_rd;
      else     exp_if_rd = x_rd;
    end
    chk("if_ack",   64'(if_ack),   64'(acking && !own));
    chk("d_ack",    64'(d_ack),    64'(acking && own));
    chk("if_rdata", 64'(if_rdata), 64'(exp_if_rd));
    chk("d_rdata",  64'(d_rdata),  64'(exp_d_rd));
    if (if_ack === 1'b1) begin obs_order.push_back(0); n_if_ack++; last_if_ack_cyc = cyc; end
    if (d_ack === 1'b1)  begin obs_order.push_back(1); n_d_ack++; end

    if (acking) begin
      if (own) d_pend = 0;
      else     f_pend = 0;
      busy = 0;
      next_arb = cyc + 1;
    end
    if (!f_pend && f_q.size() > 0 && $urandom_range(99) < req_prob) begin
      f_pend = 1; f_cur = f_q.pop_front(); f_rise_cyc = cyc;
    end
    if (!d_pend && d_q.size() > 0 && $urandom_range(99) < req_prob) begin
      d_pend = 1; d_cur = d_q.pop_front();
    end
    if_req  = f_pend;
    if_addr = f_pend ? f_cur : $urandom();
    d_req   = d_pend;
    d_we    = d_pend ? d_cur.we : 1'($urandom());
    d_op    = d_pend ? d_cur.op : ops[$urandom_range(4)];
    d_addr  = d_pend ? d_cur.addr : $urandom();
    d_wdata = d_pend ? d_cur.wdata : $urandom();

    if (!reset && !busy && cyc == next_arb) begin
      if (f_pend || d_pend) begin
        own = d_pend && !(f_pend && starve == LIM);
        if (own) begin
          x_addr = d_cur.addr; x_we = d_cur.we; x_op = d_cur.op; x_wdata = d_cur.wdata;
          starve = f_pend ? ((starve < LIM) ? starve + 1 : starve) : 0;
        end else begin
          x_addr = f_cur; x_we = 1'b0; x_op = MEM_W; x_wdata = '0;
          starve = 0;
        end
        if (x_we) begin mem[x_addr] = x_wdata; x_rd = $urandom(); end
        else      x_rd = mem_rd(x_addr);
        g = (plan_g >= 0) ? plan_g : int'($urandom_range(3));
        r = (plan_r >= 0) ? plan_r : int'($urandom_range(3));
        busy = 1;
        t_arb = cyc;
      end else begin
        next_arb = cyc + 1;
      end
    end

    m_gnt    = (busy && cyc == t_arb + 1 + g) || cyc == extra_gnt;
    m_rvalid = (busy && cyc == t_arb + 2 + g + r) || cyc == extra_rv;
    m_rdata  = (busy && m_rvalid) ? x_rd : $urandom();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_quiet(input int maxc);
    int n = 0;
    while ((busy || f_pend || d_pend || f_q.size() > 0 || d_q.size() > 0) && n < maxc) begin
      step();
      n++;
    end
    chk("quiet_timeout", 64'(n < maxc), 64'(1));
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 50) begin step(); n++; end
    chk("grant_timeout", 64'(busy), 64'(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ord [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    dreq_t dr;
    reset = 1'b1;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_op = MEM_B; d_addr = '0; d_wdata = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    cyc = 0; busy = 0; starve = 0; exp_if_rd = '0; exp_d_rd = '0;
    next_arb = 1 << 30;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b0;
    next_arb = cyc;

    // lone fetch
    mem[32'h100] = 32'h0050_0093;
    plan_g = 0; plan_r = 0; n_d_ack = 0;
    f_q.push_back(32'h100);
    run_until_quiet(100);
    chk("lone_if_rdata", 64'(if_rdata), 64'(32'h0050_0093));
    chk("lone_latency", 64'(last_if_ack_cyc - f_rise_cyc), 64'(3));
    chk("lone_d_acks", 64'(n_d_ack), 64'(0));

    // store then load on the data port
    n_d_ack = 0;
    d_q.push_back('{1'b1, MEM_W, 32'h2000, 32'hDEAD_BEEF});
    d_q.push_back('{1'b0, MEM_W, 32'h2000, 32'h0});
    run_until_quiet(100);
    chk("sl_d_acks", 64'(n_d_ack), 64'(2));
    chk("sl_load_data", 64'(d_rdata), 64'(32'hDEAD_BEEF));

    // contention: both ports request together and keep re-requesting
    plan_g = -1; plan_r = -1;
    obs_order.delete();
    for (int i = 0; i < 8; i++) begin
      dr.we = 1'($urandom()); dr.op = ops[$urandom_range(4)];
      dr.addr = 32'h3000 + 32'($urandom_range(15)) * 4; dr.wdata = $urandom();
      d_q.push_back(dr);
    end
    f_q.push_back(32'h400);
    f_q.push_back(32'h404);
    run_until_quiet(500);
    chk("order_len", 64'(obs_order.size()), 64'(10));
    for (int i = 0; i < 10 && i < obs_order.size(); i++)
      chk($sformatf("order_%0d", i), 64'(obs_order[i]), 64'(exp_ord[i]));

    // back-pressure: grant withheld 5 cycles, response 3 cycles after grant
    plan_g = 5; plan_r = 2; n_if_ack = 0;
    f_q.push_back(32'h808);
    run_until_quiet(100);
    chk("bp_acks", 64'(n_if_ack), 64'(1));
    chk("bp_ack_after_rvalid", 64'(last_if_ack_cyc - (t_arb + 2 + 5 + 2)), 64'(1));

    // spurious rvalid in IDLE, spurious gnt in WAIT
    plan_g = 0; plan_r = 3; n_if_ack = 0; n_d_ack = 0;
    extra_rv = cyc + 2;
    repeat (5) step();
    chk("spur_if_acks", 64'(n_if_ack), 64'(0));
    chk("spur_d_acks", 64'(n_d_ack), 64'(0));
    extra_rv = -1;
    f_q.push_back(32'h80C);
    wait_busy();
    extra_gnt = t_arb + 3;
    run_until_quiet(100);
    extra_gnt = -1;
    chk("spur_fetch_acks", 64'(n_if_ack), 64'(1));

    // reset during WAIT
    mem[32'h900] = 32'h1234_5678;
    plan_g = 0; plan_r = 4;
    f_q.push_back(32'h900);
    wait_busy();
    while (cyc < t_arb + 3) step();
    #2 reset = 1'b1;
    #1 chk_reset_outputs("mid");
    busy = 0; starve = 0; exp_if_rd = '0; exp_d_rd = '0;
    next_arb = 1 << 30;
    m_gnt = 0; m_rvalid = 0;
    @(negedge clk);
    cyc++;
    step();
    step();
    reset = 1'b0;
    next_arb = cyc;
    n_if_ack = 0;
    run_until_quiet(100);
    chk("rst_fetch_acks", 64'(n_if_ack), 64'(1));
    chk("rst_fetch_data", 64'(if_rdata), 64'(32'h1234_5678));

    // randomized traffic
    plan_g = -1; plan_r = -1; req_prob = 40;
    for (int i = 0; i < 150; i++) begin
      dr.we = 1'($urandom()); dr.op = ops[$urandom_range(4)];
      dr.addr = 32'h3000 + 32'($urandom_range(15)) * 4; dr.wdata = $urandom();
      d_q.push_back(dr);
      f_q.push_back(($urandom_range(1) == 0 ? 32'h3000 : 32'h100) + 32'($urandom_range(15)) * 4);
    end
    run_until_quiet(20000);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
